// File: rtl/csa_pkg.sv
// ============================================================================
//  Module     : csa_pkg
//  Description: Shared types for the carry-save accumulation sequencer:
//               FSM state encoding, default internal width and 3:2 compressor.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package csa_pkg;

    localparam int C_OP_W    = 4;
    localparam int C_MAX_OPS = 16;
    // Wide enough that MAX_OPS operands of all-ones never overflow.
    localparam int C_INT_W   = C_OP_W + $clog2(C_MAX_OPS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef logic [C_INT_W-1:0] csa_word_t;

    typedef struct packed {
        csa_word_t sum;
        csa_word_t carry;
    } csa_pair_t;

    // Carry leaves already shifted into its weight; the MSB falls off.
    function automatic csa_pair_t csa3(input csa_word_t a, input csa_word_t b, input csa_word_t c);
        csa_pair_t r;
        csa_word_t maj;
        maj     = (a & b) | (a & c) | (b & c);
        r.sum   = a ^ b ^ c;
        r.carry = maj << 1;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/csa_3to2.sv
// ============================================================================
//  Module     : csa_3to2
//  Description: Combinational 3:2 compressor of width W producing a redundant
//               (sum, shifted carry) pair.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_3to2
    import csa_pkg::*;
#(
    parameter int W = C_INT_W
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_carry
);

    generate
        if (W == C_INT_W) begin : g_pkg_fn
            csa_pair_t w_pair;
            assign w_pair  = csa3(i_a, i_b, i_c);
            assign o_sum   = w_pair.sum;
            assign o_carry = w_pair.carry;
        end else begin : g_generic
            logic [W-1:0] w_maj;
            assign w_maj   = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
            assign o_sum   = i_a ^ i_b ^ i_c;
            assign o_carry = {w_maj[W-2:0], 1'b0};
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/csa_accum_seq.sv
// ============================================================================
//  Module     : csa_accum_seq
//  Description: Burst sequencer folding one operand per beat into a carry-save
//               pair, then resolving the total in one carry-propagate cycle.
//               Optional saturation enabled by macro CSA_ACC_SAT_EN.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_accum_seq
    import csa_pkg::*;
#(
    parameter int OP_W    = 4,
    parameter int MAX_OPS = 16,
    parameter int ACC_W   = 8,
    parameter int CNT_W   = $clog2(MAX_OPS + 1),
    parameter int INT_W   = OP_W + $clog2(MAX_OPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] op_count,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_sat
);

    localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(MAX_OPS);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] w_count_clamped;
    logic [INT_W-1:0] r_sum;
    logic [INT_W-1:0] r_carry;
    logic [INT_W-1:0] w_operand;
    logic [INT_W-1:0] w_csa_sum;
    logic [INT_W-1:0] w_csa_carry;
    logic [INT_W-1:0] w_total;
    logic [ACC_W-1:0] r_out_sum;
    logic [ACC_W-1:0] w_res_sum;
    logic             r_out_sat;
    logic             w_res_sat;
    logic             w_fire;
    logic             w_last_beat;

    assign w_count_clamped = (op_count > C_MAX_CNT) ? C_MAX_CNT : op_count;
    assign w_fire          = in_valid && (r_state == ST_ACCUM);
    assign w_last_beat     = w_fire && (r_remaining == CNT_W'(1));
    assign w_operand       = INT_W'(in_data);

    csa_3to2 #(
        .W (INT_W)
    ) u_csa (
        .i_a     (r_sum),
        .i_b     (r_carry),
        .i_c     (w_operand),
        .o_sum   (w_csa_sum),
        .o_carry (w_csa_carry)
    );

    assign w_total = r_sum + r_carry;

`ifdef CSA_ACC_SAT_EN
    // One spare bit so the compare is valid whichever of INT_W/ACC_W is wider.
    localparam int C_CMP_W = ((INT_W > ACC_W) ? INT_W : ACC_W) + 1;
    logic [C_CMP_W-1:0] w_total_ext;
    logic               w_over;
    assign w_total_ext = C_CMP_W'(w_total);
    assign w_over      = w_total_ext > C_CMP_W'({ACC_W{1'b1}});
    assign w_res_sum   = w_over ? {ACC_W{1'b1}} : w_total_ext[ACC_W-1:0];
    assign w_res_sat   = w_over;
`else
    assign w_res_sum   = ACC_W'(w_total);
    assign w_res_sat   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_state_nxt = (op_count == '0) ? ST_DONE : ST_ACCUM;
            ST_ACCUM:   if (w_last_beat) w_state_nxt = ST_RESOLVE;
            ST_RESOLVE: w_state_nxt = ST_DONE;
            ST_DONE:    if (out_ready) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining <= '0;
            r_sum       <= '0;
            r_carry     <= '0;
            r_out_sum   <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_remaining <= w_count_clamped;
                        r_sum       <= '0;
                        r_carry     <= '0;
                        r_out_sum   <= '0;
                        r_out_sat   <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (w_fire) begin
                        r_sum       <= w_csa_sum;
                        r_carry     <= w_csa_carry;
                        r_remaining <= r_remaining - CNT_W'(1);
                    end
                end
                ST_RESOLVE: begin
                    r_out_sum <= w_res_sum;
                    r_out_sat <= w_res_sat;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_DONE);
    assign out_sum   = r_out_sum;
    assign out_sat   = r_out_sat;

endmodule

`default_nettype wire

// File: tb/tb_csa_accum_seq.sv
// ============================================================================
//  Module     : tb_csa_accum_seq
//  Description: Scoreboard bench driving two sequencers (ACC_W=8 and ACC_W=6)
//               with identical bursts and checking totals and handshakes.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csa_accum_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] op_count = '0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = '0;
    logic       out_ready = 1'b0;

    logic       a_busy, a_in_ready, a_out_valid, a_out_sat;
    logic [7:0] a_out_sum;
    logic       b_busy, b_in_ready, b_out_valid, b_out_sat;
    logic [5:0] b_out_sum;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] s8;
        logic       sat8;
        logic [5:0] s6;
        logic       sat6;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    csa_accum_seq #(.ACC_W(8)) u_dut_a (
        .clk (clk), .rst (rst), .start (start), .op_count (op_count), .busy (a_busy),
        .in_valid (in_valid), .in_ready (a_in_ready), .in_data (in_data),
        .out_valid (a_out_valid), .out_ready (out_ready), .out_sum (a_out_sum), .out_sat (a_out_sat)
    );

    csa_accum_seq #(.ACC_W(6)) u_dut_b (
        .clk (clk), .rst (rst), .start (start), .op_count (op_count), .busy (b_busy),
        .in_valid (in_valid), .in_ready (b_in_ready), .in_data (in_data),
        .out_valid (b_out_valid), .out_ready (out_ready), .out_sum (b_out_sum), .out_sat (b_out_sat)
    );

    function automatic exp_t model(input int unsigned total);
        exp_t e;
        e.s8   = total[7:0];
        e.sat8 = 1'b0;
`ifdef CSA_ACC_SAT_EN
        if (total > 63) begin
            e.s6 = 6'h3f; e.sat6 = 1'b1;
        end else begin
            e.s6 = total[5:0]; e.sat6 = 1'b0;
        end
`else
        e.s6   = total[5:0];
        e.sat6 = 1'b0;
`endif
        return e;
    endfunction

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_burst(input int cnt, input int unsigned total, input bit push);
        if (push) sb.push_back(model(total));
        start = 1'b1;
        op_count = cnt[4:0];
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int d);
        in_valid = 1'b1;
        in_data = d[3:0];
        tick();
        in_valid = 1'b0;
    endtask

    task automatic get_result(output exp_t obs, output bit ok);
        int n = 0;
        while (!a_out_valid && n < 60) begin
            tick();
            n++;
        end
        ok = a_out_valid && b_out_valid;
        obs = {a_out_sum, a_out_sat, b_out_sum, b_out_sat};
        if (a_out_valid) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if ({a_busy, a_in_ready, a_out_valid, a_out_sat, a_out_sum, b_busy, b_in_ready, b_out_valid, b_out_sat, b_out_sum} !== '0) begin
            failures++;
            $display("FAIL reset_hold: a=%b/%h b=%b/%h required all zero", {a_busy, a_in_ready, a_out_valid, a_out_sat}, a_out_sum, {b_busy, b_in_ready, b_out_valid, b_out_sat}, b_out_sum);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (a_busy !== 1'b0 || a_out_valid !== 1'b0 || b_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b valid=%b required 0 0", a_busy, a_out_valid);
        end
    endtask

    task automatic test_basic();
        exp_t obs, e;
        bit ok;
        start_burst(3, 22, 1'b1);
        feed(4); feed(6); feed(12);
        checks++;
        if (a_out_valid !== 1'b0 || a_busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_resolve: out_valid=%b busy=%b required 0 1", a_out_valid, a_busy);
        end
        tick();
        checks++;
        if (a_out_valid !== 1'b1 || b_out_valid !== 1'b1) begin
            failures++;
            $display("FAIL basic_latency: out_valid=%b/%b required 1/1", a_out_valid, b_out_valid);
        end
        get_result(obs, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || obs !== e) begin
            failures++;
            $display("FAIL basic_result: ok=%b got %h required %h", ok, obs, e);
        end
    endtask

    task automatic test_stall();
        exp_t obs, e;
        bit ok;
        int gap_err = 0;
        int ops[4] = '{11, 2, 4, 7};
        start_burst(4, 24, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) begin
                repeat (2) begin
                    tick();
                    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) gap_err++;
                end
            end
            feed(ops[i]);
        end
        checks++;
        if (gap_err != 0) begin
            failures++;
            $display("FAIL stall_ready: low cycles=%0d required 0", gap_err);
        end
        get_result(obs, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || obs !== e) begin
            failures++;
            $display("FAIL stall_result: ok=%b got %h required %h", ok, obs, e);
        end
    endtask

    task automatic test_full_and_clamp();
        exp_t obs, e;
        bit ok;
        start_burst(16, 240, 1'b1);
        repeat (16) feed(15);
        get_result(obs, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || obs !== e) begin
            failures++;
            $display("FAIL full_result: ok=%b got %h required %h", ok, obs, e);
        end
        tick();
        start_burst(31, 16, 1'b1);
        repeat (16) feed(1);
        checks++;
        if (a_in_ready !== 1'b0 || a_busy !== 1'b1) begin
            failures++;
            $display("FAIL clamp_ready: in_ready=%b busy=%b required 0 1", a_in_ready, a_busy);
        end
        get_result(obs, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || obs !== e) begin
            failures++;
            $display("FAIL clamp_result: ok=%b got %h required %h", ok, obs, e);
        end
        tick();
    endtask

    task automatic test_zero();
        exp_t obs, e;
        bit ok;
        start_burst(0, 0, 1'b1);
        checks++;
        if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL zero_direct: out_valid=%b in_ready=%b required 1 0", a_out_valid, a_in_ready);
        end
        get_result(obs, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || obs !== e) begin
            failures++;
            $display("FAIL zero_result: ok=%b got %h required %h", ok, obs, e);
        end
        tick();
    endtask

    task automatic test_sat();
        exp_t obs, e;
        bit ok;
        start_burst(8, 120, 1'b1);
        repeat (8) feed(15);
        get_result(obs, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || obs !== e) begin
            failures++;
            $display("FAIL sat_result: ok=%b got %h required %h", ok, obs, e);
        end
        tick();
    endtask

    task automatic test_hold();
        exp_t obs, e;
        bit ok;
        start_burst(3, 6, 1'b1);
        feed(1); feed(2); feed(3);
        tick();
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'b0;
            start = (i == 0);
            op_count = 5'd5;
            tick();
            start = 1'b0;
            checks++;
            if (a_out_valid !== 1'b1 || a_out_sum !== sb[0].s8 || b_out_sum !== sb[0].s6) begin
                failures++;
                $display("FAIL hold_stable: valid=%b sum=%0d/%0d required 1 %0d/%0d", a_out_valid, a_out_sum, b_out_sum, sb[0].s8, sb[0].s6);
            end
        end
        get_result(obs, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || obs !== e) begin
            failures++;
            $display("FAIL hold_result: ok=%b got %h required %h", ok, obs, e);
        end
        checks++;
        if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
            failures++;
            $display("FAIL hold_idle: busy=%b/%b required 0/0", a_busy, b_busy);
        end
        tick();
        checks++;
        if (a_busy !== 1'b0 || a_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_start_ignored: busy=%b valid=%b required 0 0", a_busy, a_out_valid);
        end
    endtask

    task automatic test_reset_mid();
        exp_t obs, e;
        bit ok;
        start_burst(4, 0, 1'b0);
        feed(9); feed(5);
        rst = 1'b1;
        tick();
        checks++;
        if ({a_busy, a_in_ready, a_out_valid, a_out_sat, a_out_sum, b_busy, b_in_ready, b_out_valid, b_out_sat, b_out_sum} !== '0) begin
            failures++;
            $display("FAIL reset_mid: a=%b/%h b=%b/%h required all zero", {a_busy, a_in_ready, a_out_valid, a_out_sat}, a_out_sum, {b_busy, b_in_ready, b_out_valid, b_out_sat}, b_out_sum);
        end
        rst = 1'b0;
        tick();
        start_burst(2, 20, 1'b1);
        feed(10); feed(10);
        get_result(obs, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || obs !== e) begin
            failures++;
            $display("FAIL reset_mid_result: ok=%b got %h required %h", ok, obs, e);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        tick();
        test_stall();
        tick();
        test_full_and_clamp();
        test_zero();
        test_sat();
        test_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
